arm_emit_seq: RTL and testbench

ARM_EMIT_SEQ -- requirements
Module: arm_emit_seq

---
 rtl/arm_emit_pkg.sv | 29 ++
 rtl/arm_tmpl_rom.sv | 20 ++
 rtl/arm_emit_seq.sv | 121 ++++++++++++
 tb/tb_arm_emit_seq.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_emit_pkg.sv
// Shared types and constants for the ARM instruction emitter: FSM states,
// template table and template ROM contents.
package arm_emit_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    localparam int unsigned ADR_W      = 3;
    localparam int unsigned TMPL_N     = 4;
    localparam int unsigned TMPL_PTR_W = 4;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned LEN_W      = 3;
    localparam int unsigned ROM_W      = 32;
    localparam int unsigned ROM_USED   = 10;

    localparam logic [ADR_W-1:0] OP_ADR_INVALID = 3'b111;

    // Start address and word count of each template in the ROM.
    localparam logic [TMPL_PTR_W-1:0] TMPL_BASE [TMPL_N] = '{4'd0, 4'd1, 4'd3, 4'd6};
    localparam logic [LEN_W-1:0]      TMPL_LEN  [TMPL_N] = '{3'd1, 3'd2, 3'd3, 3'd4};

    localparam logic [ROM_W-1:0] ROM_WORDS [ROM_USED] = '{
        32'hE1A00000, 32'hE49D0004, 32'hE52D0004, 32'hE49D1004, 32'hE49D0004,
        32'hE0800001, 32'hE49D1004, 32'hE49D0004, 32'hE0800001, 32'hE52D0004
    };

endpackage

// File: rtl/arm_tmpl_rom.sv
// Combinational template ROM: word at address ptr, zero beyond the populated entries.
module arm_tmpl_rom
    import arm_emit_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned DEPTH  = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic [PTR_W-1:0]  ptr,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        word = '0;
        if (32'(ptr) < ROM_USED) begin
            word = WORD_W'(ROM_WORDS[ptr]);
        end
    end

endmodule

// File: rtl/arm_emit_seq.sv
// ARM instruction template emitter: one accepted opcode index streams its
// template words with valid/ready. Optional counters under ARM_EMIT_STATS_EN.
module arm_emit_seq
    import arm_emit_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned TMPL_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [ADR_W-1:0]  op_adr,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [WORD_W-1:0] inst_word,
    output logic              inst_last,
    output logic              op_err
`ifdef ARM_EMIT_STATS_EN
    ,
    output logic [15:0]       emit_cnt,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(TMPL_DEPTH);

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_err_q, op_err_d;
    logic               adr_ok_c;

    assign adr_ok_c = (op_adr != OP_ADR_INVALID) && !op_adr[2];
    assign op_err   = op_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            op_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            op_err_q <= op_err_d;
        end
    end

    // Next-state and handshake decode; stalls simply hold ptr/cnt.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        op_err_d   = 1'b0;
        op_ready   = 1'b0;
        inst_valid = 1'b0;
        inst_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (adr_ok_c) begin
                        ptr_d   = PTR_W'(TMPL_BASE[op_adr[1:0]]);
                        cnt_d   = CNT_W'(TMPL_LEN[op_adr[1:0]] - LEN_W'(1));
                        state_d = ST_EMIT;
                    end else begin
                        op_err_d = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                inst_valid = 1'b1;
                inst_last  = (cnt_q == '0);
                if (inst_ready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    arm_tmpl_rom #(
        .WORD_W (WORD_W),
        .DEPTH  (TMPL_DEPTH)
    ) u_rom (
        .ptr  (ptr_q),
        .word (inst_word)
    );

`ifdef ARM_EMIT_STATS_EN
    logic [15:0] emit_cnt_q;
    logic [7:0]  err_cnt_q;

    // Accepted-word count wraps; error count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            emit_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (inst_valid && inst_ready) begin
                emit_cnt_q <= emit_cnt_q + 16'd1;
            end
            if (op_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign emit_cnt = emit_cnt_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_arm_emit_seq.sv
// Self-checking bench for arm_emit_seq: queue-based reference model of the
// pending template words, directed scenarios plus randomized traffic.
module tb_arm_emit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_adr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic        inst_last;
    logic        op_err;
`ifdef ARM_EMIT_STATS_EN
    logic [15:0] emit_cnt;
    logic [7:0]  err_cnt;
`endif

    arm_emit_seq #(.WORD_W(32), .TMPL_DEPTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_adr     (op_adr),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_word  (inst_word),
        .inst_last  (inst_last),
        .op_err     (op_err)
`ifdef ARM_EMIT_STATS_EN
        ,
        .emit_cnt   (emit_cnt),
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [31:0] rom_m [16] = '{32'hE1A00000, 32'hE49D0004, 32'hE52D0004, 32'hE49D1004,
                                32'hE49D0004, 32'hE0800001, 32'hE49D1004, 32'hE49D0004,
                                32'hE0800001, 32'hE52D0004, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0};
    int          base_m [4] = '{0, 1, 3, 6};
    int          len_m  [4] = '{1, 2, 3, 4};

    // Reference model: words still owed to downstream, and the pending error pulse.
    logic [31:0] pend [$];
    logic        err_m = 1'b0;
    logic [15:0] emit_m = '0;
    logic [7:0]  errc_m = '0;

    function automatic logic m_valid();
        return pend.size() != 0;
    endfunction

    function automatic logic m_last();
        return pend.size() == 1;
    endfunction

    function automatic logic [31:0] m_word();
        return (pend.size() != 0) ? pend[0] : 32'h0;
    endfunction

    task automatic model_reset();
        pend.delete();
        err_m  = 1'b0;
        emit_m = '0;
        errc_m = '0;
    endtask

    // Advance one clock, updating the model from the inputs seen at that edge.
    task automatic advance();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (err_m && errc_m != 8'hFF) errc_m = errc_m + 8'd1;
            err_m = 1'b0;
            if (pend.size() != 0) begin
                if (inst_ready) begin
                    void'(pend.pop_front());
                    emit_m = emit_m + 16'd1;
                end
            end else if (op_valid) begin
                if (op_adr < 3'd4) begin
                    for (int i = 0; i < len_m[op_adr]; i++) pend.push_back(rom_m[base_m[op_adr] + i]);
                end else begin
                    err_m = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b0; op_adr = 3'd0; inst_ready = 1'b0;
        model_reset();
        #3;
        n_vec++;
        if (op_ready !== 1'b1) begin n_err++; $display("FAIL reset_op_ready: got %b want 1", op_ready); end
        n_vec++;
        if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
        n_vec++;
        if (inst_last !== 1'b0) begin n_err++; $display("FAIL reset_inst_last: got %b want 0", inst_last); end
        n_vec++;
        if (op_err !== 1'b0) begin n_err++; $display("FAIL reset_op_err: got %b want 0", op_err); end
        advance();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_templates();
        logic [31:0] lit3 [4] = '{32'hE49D1004, 32'hE49D0004, 32'hE0800001, 32'hE52D0004};
        int          k;
        for (int a = 0; a < 4; a++) begin
            op_valid = 1'b1; op_adr = 3'(a); inst_ready = 1'b1;
            k = 0;
            for (int c = 0; c < len_m[a] + 2; c++) begin
                @(negedge clk);
                n_vec++;
                if (inst_valid !== m_valid() || op_ready !== !m_valid() || inst_last !== m_last() ||
                    op_err !== err_m || (m_valid() && inst_word !== m_word())) begin
                    n_err++;
                    $display("FAIL tmpl%0d_c%0d: valid=%b ready=%b word=%h last=%b err=%b, want valid=%b ready=%b word=%h last=%b err=%b",
                             a, c, inst_valid, op_ready, inst_word, inst_last, op_err,
                             m_valid(), !m_valid(), m_word(), m_last(), err_m);
                end
                if (inst_valid === 1'b1) begin
                    n_vec++;
                    if (a == 3 && (inst_word !== lit3[k] || inst_last !== (k == 3))) begin
                        n_err++;
                        $display("FAIL tmpl3_word%0d: got %h last=%b want %h last=%b", k, inst_word, inst_last, lit3[k], k == 3);
                    end else if (a == 0 && (inst_word !== 32'hE1A00000 || inst_last !== 1'b1)) begin
                        n_err++;
                        $display("FAIL tmpl0_word: got %h last=%b want e1a00000 last=1", inst_word, inst_last);
                    end
                    k++;
                end
                advance();
                op_valid = 1'b0;
            end
        end
    endtask

    task automatic test_stall();
        logic rdy_seq [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        op_valid = 1'b1; op_adr = 3'd2; inst_ready = 1'b1;
        advance();
        op_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            inst_ready = rdy_seq[c];
            @(negedge clk);
            n_vec++;
            if (inst_valid !== m_valid() || op_ready !== !m_valid() || inst_last !== m_last() ||
                op_err !== err_m || (m_valid() && inst_word !== m_word())) begin
                n_err++;
                $display("FAIL stall_c%0d: valid=%b ready=%b word=%h last=%b, want valid=%b ready=%b word=%h last=%b",
                         c, inst_valid, op_ready, inst_word, inst_last, m_valid(), !m_valid(), m_word(), m_last());
            end
            if (c >= 1 && c <= 4) begin
                n_vec++;
                if (inst_word !== 32'hE49D0004 || inst_last !== 1'b0 || inst_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_hold_c%0d: got %h last=%b valid=%b want e49d0004 last=0 valid=1", c, inst_word, inst_last, inst_valid);
                end
            end
            if (c == 5) begin
                n_vec++;
                if (inst_word !== 32'hE0800001 || inst_last !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_final: got %h last=%b want e0800001 last=1", inst_word, inst_last);
                end
            end
            advance();
        end
    endtask

    task automatic test_invalid();
        logic err_want [3] = '{1'b0, 1'b1, 1'b0};
        op_valid = 1'b1; op_adr = 3'd7; inst_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (op_err !== err_want[c] || op_err !== err_m || inst_valid !== 1'b0 || op_ready !== 1'b1) begin
                n_err++;
                $display("FAIL invalid_c%0d: err=%b valid=%b ready=%b, want err=%b valid=0 ready=1",
                         c, op_err, inst_valid, op_ready, err_want[c]);
            end
            advance();
            op_valid = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        op_valid = 1'b1; op_adr = 3'd3; inst_ready = 1'b1;
        advance();
        op_valid = 1'b0;
        advance();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (inst_valid !== 1'b0 || op_ready !== 1'b1 || inst_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: valid=%b ready=%b last=%b want valid=0 ready=1 last=0", inst_valid, op_ready, inst_last);
        end
        advance();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (inst_valid !== 1'b0 || op_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_release: valid=%b ready=%b want valid=0 ready=1", inst_valid, op_ready);
        end
        advance();
        op_valid = 1'b1; op_adr = 3'd1;
        advance();
        op_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++;
            if (inst_valid !== 1'b1 || inst_word !== (c == 0 ? 32'hE49D0004 : 32'hE52D0004) ||
                inst_last !== (c == 1) || inst_word !== m_word()) begin
                n_err++;
                $display("FAIL reset_mid_tmpl1_w%0d: valid=%b word=%h last=%b want valid=1 word=%h last=%b",
                         c, inst_valid, inst_word, inst_last, m_word(), c == 1);
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            op_valid   = 1'($urandom_range(0, 1));
            op_adr     = 3'($urandom_range(0, 7));
            inst_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_vec++;
            if (inst_valid !== m_valid() || op_ready !== !m_valid() || inst_last !== m_last() ||
                op_err !== err_m || (m_valid() && inst_word !== m_word())) begin
                n_err++;
                $display("FAIL rand_c%0d: valid=%b ready=%b word=%h last=%b err=%b, want valid=%b ready=%b word=%h last=%b err=%b",
                         c, inst_valid, op_ready, inst_word, inst_last, op_err,
                         m_valid(), !m_valid(), m_word(), m_last(), err_m);
            end
`ifdef ARM_EMIT_STATS_EN
            n_vec++;
            if (emit_cnt !== emit_m || err_cnt !== errc_m) begin
                n_err++;
                $display("FAIL rand_stats_c%0d: emit=%h err=%h want emit=%h err=%h", c, emit_cnt, err_cnt, emit_m, errc_m);
            end
`endif
            advance();
        end
        op_valid = 1'b0; inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) advance();
    endtask

`ifdef ARM_EMIT_STATS_EN
    task automatic test_stats();
        rst = 1'b1; op_valid = 1'b0; inst_ready = 1'b1;
        advance();
        rst = 1'b0;
        for (int t = 0; t < 16384; t++) begin
            op_valid = 1'b1; op_adr = 3'd3;
            advance();
            op_valid = 1'b0;
            for (int w = 0; w < 4; w++) advance();
        end
        op_valid = 1'b1; op_adr = 3'd0;
        advance();
        op_valid = 1'b0;
        advance();
        advance();
        n_vec++;
        if (emit_cnt !== 16'd1 || emit_cnt !== emit_m) begin
            n_err++;
            $display("FAIL stats_emit_wrap: got %h want 0001 (model %h)", emit_cnt, emit_m);
        end
        op_valid = 1'b1; op_adr = 3'd7;
        for (int e = 0; e < 300; e++) advance();
        op_valid = 1'b0;
        advance();
        advance();
        n_vec++;
        if (err_cnt !== 8'hFF || err_cnt !== errc_m) begin
            n_err++;
            $display("FAIL stats_err_sat: got %h want ff (model %h)", err_cnt, errc_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_templates();
        test_stall();
        test_invalid();
        test_reset_mid();
        test_random();
`ifdef ARM_EMIT_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
